// File: rtl/wave_write_arbiter.sv
// wave_write_arbiter
//
// Shares one wave-capture RAM write port among four sample streams (mixed
// output plus notes 1-3). Each stream owns a one-entry holding register; a
// round-robin arbiter grants at most one stream per cycle, and the granted
// sample is written into that stream's RAM region at its own wrapping pointer.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   new_sample  bit i: one-cycle pulse, stream i sample valid
//   samples     stream i at [16*i+15:16*i], 16-bit two's complement
//   freeze      1 = no grants issued; capture still happens
//   wr_ready    RAM write port free this cycle
//   wr_en       registered one-cycle write strobe
//   wr_addr     registered {chan[1:0], ptr[ADDR_WIDTH-1:0]}
//   wr_data     registered sample[15:8] ^ 8'h80 (offset binary)
//   drop_cnt    stream i at [8*i+7:8*i], saturating overwrite count
//
// Configuration:
//   WAVE_ARB_DROP_CNT_EN defined   -> per-stream saturating drop counters
//   WAVE_ARB_DROP_CNT_EN undefined -> no counter flops, drop_cnt tied to 0

module wave_write_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            new_sample,
  input  logic [63:0]           samples,
  input  logic                  freeze,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH+1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [31:0]           drop_cnt
);

  // Only the upper byte of each sample is ever written, so the holding
  // registers keep just that byte, already converted to offset binary.
  logic [7:0]            pend_data_q  [N_REQ];
  logic [7:0]            pend_data_d  [N_REQ];
  logic [N_REQ-1:0]      pend_valid_q;
  logic [N_REQ-1:0]      pend_valid_d;
  logic [ADDR_WIDTH-1:0] ptr_q        [N_REQ];
  logic [ADDR_WIDTH-1:0] ptr_d        [N_REQ];
  logic [1:0]            last_grant_q;
  logic [1:0]            last_grant_d;

  logic                  wr_en_q;
  logic [ADDR_WIDTH+1:0] wr_addr_q;
  logic [ADDR_WIDTH+1:0] wr_addr_d;
  logic [7:0]            wr_data_q;
  logic [7:0]            wr_data_d;

  logic                  grant_valid;
  logic [1:0]            gnt;
  logic [1:0]            search_idx;
  logic                  found;
  logic [N_REQ-1:0]      grant_vec;

  logic                  unused_sample_lsbs;
  assign unused_sample_lsbs = ^{samples[55:48], samples[39:32], samples[23:16], samples[7:0]};

  // Round-robin search starting one past the last granted stream.
  always_comb begin
    gnt        = last_grant_q;
    found      = 1'b0;
    search_idx = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      search_idx = last_grant_q + 2'(k);
      if (!found && pend_valid_q[search_idx]) begin
        gnt   = search_idx;
        found = 1'b1;
      end
    end
  end

  assign grant_valid = wr_ready && !freeze && (|pend_valid_q);

  always_comb begin
    grant_vec = '0;
    if (grant_valid) begin
      grant_vec[gnt] = 1'b1;
    end
  end

  // Holding registers and pointers. A capture in the same cycle as the
  // stream's grant keeps pend_valid set: the old byte goes out, the new one
  // stays pending.
  always_comb begin
    pend_valid_d = pend_valid_q;
    last_grant_d = last_grant_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pend_data_d[i] = pend_data_q[i];
      ptr_d[i]       = ptr_q[i];
      if (grant_vec[i]) begin
        pend_valid_d[i] = 1'b0;
        ptr_d[i]        = ptr_q[i] + 1'b1;
      end
      if (new_sample[i]) begin
        pend_data_d[i]  = samples[16*i+8 +: 8] ^ 8'h80;
        pend_valid_d[i] = 1'b1;
      end
    end
    if (grant_valid) begin
      last_grant_d = gnt;
    end
  end

  // Address/data hold their last values when no grant is issued.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_valid) begin
      wr_addr_d = {gnt, ptr_q[gnt]};
      wr_data_d = pend_data_q[gnt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= '0;
      last_grant_q <= 2'd3;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        pend_data_q[i] <= '0;
        ptr_q[i]       <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= grant_valid;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        pend_data_q[i] <= pend_data_d[i];
        ptr_q[i]       <= ptr_d[i];
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef WAVE_ARB_DROP_CNT_EN
  logic [7:0] drop_q [N_REQ];
  logic [7:0] drop_d [N_REQ];

  // A drop is a capture onto a still-held sample that is not leaving this cycle.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      drop_d[i] = drop_q[i];
      if (new_sample[i] && pend_valid_q[i] && !grant_vec[i] && (drop_q[i] != 8'hFF)) begin
        drop_d[i] = drop_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (reset) begin
        drop_q[i] <= '0;
      end else begin
        drop_q[i] <= drop_d[i];
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      drop_cnt[8*i +: 8] = drop_q[i];
    end
  end
`else
  assign drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wave_write_arbiter.sv
module tb_wave_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  new_sample;
  logic [63:0] samples;
  logic        freeze;
  logic        wr_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [31:0] drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef WAVE_ARB_DROP_CNT_EN
  localparam logic [31:0] DropOne = 32'h0000_0100;
`else
  localparam logic [31:0] DropOne = 32'h0000_0000;
`endif

  wave_write_arbiter #(
    .N_REQ      (4),
    .ADDR_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .new_sample (new_sample),
    .samples    (samples),
    .freeze     (freeze),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    new_sample = '0;
    freeze     = 1'b0;
    wr_ready   = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    wr_ready = 1'b1;
  endtask

  task automatic set_stream(input int s, input logic [15:0] v);
    samples[16*s +: 16] = v;
  endtask

  task automatic pulse(input logic [3:0] m);
    new_sample = m;
    tick();
    new_sample = '0;
  endtask

  initial begin
    samples    = '0;
    new_sample = '0;
    freeze     = 1'b0;
    wr_ready   = 1'b0;
    reset      = 1'b1;
    #1;

    // Reset state
    do_reset();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Contention: all four at once, order 0,1,2,3 each at ptr 0
    samples = {16'h4400, 16'h3300, 16'h2200, 16'h1100};
    pulse(4'b1111);
    check("cont_no_early_wr", 64'(wr_en), 64'd0);
    tick();
    check("cont0_en", 64'(wr_en), 64'd1);
    check("cont0_addr", 64'(wr_addr), 64'h000);
    check("cont0_data", 64'(wr_data), 64'h91);
    tick();
    check("cont1_en", 64'(wr_en), 64'd1);
    check("cont1_addr", 64'(wr_addr), 64'h100);
    check("cont1_data", 64'(wr_data), 64'hA2);
    tick();
    check("cont2_en", 64'(wr_en), 64'd1);
    check("cont2_addr", 64'(wr_addr), 64'h200);
    check("cont2_data", 64'(wr_data), 64'hB3);
    tick();
    check("cont3_en", 64'(wr_en), 64'd1);
    check("cont3_addr", 64'(wr_addr), 64'h300);
    check("cont3_data", 64'(wr_data), 64'hC4);
    tick();
    check("cont_done_en", 64'(wr_en), 64'd0);
    check("cont_hold_addr", 64'(wr_addr), 64'h300);
    check("cont_hold_data", 64'(wr_data), 64'hC4);

    // Single sample on stream 2
    do_reset();
    set_stream(2, 16'h8000);
    pulse(4'b0100);
    check("single_lat0", 64'(wr_en), 64'd0);
    tick();
    check("single_en", 64'(wr_en), 64'd1);
    check("single_addr", 64'(wr_addr), 64'h200);
    check("single_data", 64'(wr_data), 64'h00);
    tick();
    check("single_end", 64'(wr_en), 64'd0);

    // Overwrite under freeze
    do_reset();
    freeze = 1'b1;
    set_stream(1, 16'h1234);
    pulse(4'b0010);
    tick();
    set_stream(1, 16'h7F00);
    pulse(4'b0010);
    tick();
    check("ovw_frozen_en", 64'(wr_en), 64'd0);
    check("ovw_drop", 64'(drop_cnt), 64'(DropOne));
    freeze = 1'b0;
    tick();
    check("ovw_en", 64'(wr_en), 64'd1);
    check("ovw_addr", 64'(wr_addr), 64'h100);
    check("ovw_data", 64'(wr_data), 64'hFF);
    tick();
    check("ovw_single_write", 64'(wr_en), 64'd0);
    check("ovw_drop_hold", 64'(drop_cnt), 64'(DropOne));

    // Pointer wrap on stream 0
    do_reset();
    set_stream(0, 16'h0000);
    for (int n = 1; n <= 257; n++) begin
      pulse(4'b0001);
      tick();
      check("wrap_en", 64'(wr_en), 64'd1);
      check("wrap_addr", 64'(wr_addr), 64'({2'd0, 8'(n - 1)}));
      tick();
    end
    check("wrap_data", 64'(wr_data), 64'h80);

    // Grant and capture on the same stream in the same cycle
    do_reset();
    set_stream(0, 16'h0500);
    pulse(4'b0001);
    set_stream(0, 16'h0600);
    pulse(4'b0001);
    check("same_old_en", 64'(wr_en), 64'd1);
    check("same_old_addr", 64'(wr_addr), 64'h000);
    check("same_old_data", 64'(wr_data), 64'h85);
    tick();
    check("same_new_en", 64'(wr_en), 64'd1);
    check("same_new_addr", 64'(wr_addr), 64'h001);
    check("same_new_data", 64'(wr_data), 64'h86);
    check("same_no_drop", 64'(drop_cnt), 64'd0);

    // Backpressure, then reset discards everything
    wr_ready = 1'b0;
    set_stream(1, 16'h1000);
    set_stream(3, 16'h3000);
    pulse(4'b1010);
    check("bp_en0", 64'(wr_en), 64'd0);
    tick();
    check("bp_en1", 64'(wr_en), 64'd0);
    pulse(4'b0010);
    tick();
    check("bp_en2", 64'(wr_en), 64'd0);
    check("bp_drop", 64'(drop_cnt), 64'(DropOne));
    do_reset();
    check("bp_rst_en", 64'(wr_en), 64'd0);
    check("bp_rst_addr", 64'(wr_addr), 64'd0);
    check("bp_rst_data", 64'(wr_data), 64'd0);
    check("bp_rst_drop", 64'(drop_cnt), 64'd0);
    tick();
    check("bp_discarded", 64'(wr_en), 64'd0);
    set_stream(0, 16'hFF00);
    set_stream(1, 16'h0100);
    pulse(4'b0011);
    tick();
    check("post_rst0_addr", 64'(wr_addr), 64'h000);
    check("post_rst0_data", 64'(wr_data), 64'h7F);
    tick();
    check("post_rst1_en", 64'(wr_en), 64'd1);
    check("post_rst1_addr", 64'(wr_addr), 64'h100);
    check("post_rst1_data", 64'(wr_data), 64'h81);
    tick();
    check("post_rst_idle", 64'(wr_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
